// File: rtl/jpeg_huffman_table_builder.sv
// Canonical Huffman table builder: holds DHT length counts per table and, on
// request, streams canonical code/length pairs plus per-length decode entries.
module jpeg_huffman_table_builder #(
  parameter int MAX_LEN    = 16,
  parameter int MAX_SYMS   = 256,
  parameter int NUM_TABLES = 4,
  parameter int IW         = $clog2(MAX_SYMS),
  parameter int LW         = $clog2(MAX_LEN + 1),
  parameter int TW         = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cnt_we,
  input  logic [TW-1:0]      cnt_tbl,
  input  logic [LW-1:0]      cnt_len,
  input  logic [7:0]         cnt_data,
  input  logic               start,
  input  logic [TW-1:0]      start_tbl,
  output logic               busy,
  output logic               code_we,
  output logic [TW-1:0]      code_tbl,
  output logic [IW-1:0]      code_idx,
  output logic [MAX_LEN-1:0] code_val,
  output logic [LW-1:0]      code_len,
  output logic               dec_we,
  output logic [LW-1:0]      dec_len,
  output logic               dec_valid,
  output logic [MAX_LEN-1:0] dec_mincode,
  output logic [MAX_LEN-1:0] dec_maxcode,
  output logic [IW-1:0]      dec_valptr,
  output logic               done,
  output logic               err_code,
  output logic               err_count
);

  localparam int CW = $clog2(MAX_LEN);
  localparam logic [MAX_LEN:0] CODE_ONE = 1;
  localparam logic [IW:0]      IDX_ONE  = 1;
  localparam logic [IW:0]      IDX_LIM  = (IW+1)'(MAX_SYMS);
  localparam logic [LW-1:0]    LEN_ONE  = 1;
  localparam logic [LW-1:0]    LEN_MAX  = LW'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_EMIT, S_FIN} state_t;

  state_t           state;
  logic [TW-1:0]    tbl;
  logic [MAX_LEN:0] code;
  logic [IW:0]      idx;
  logic [LW-1:0]    len;
  logic [7:0]       rem;
  logic [7:0]       counts [NUM_TABLES][MAX_LEN];

  logic [LW-1:0]    len_m1;
  logic [LW-1:0]    cnt_len_m1;
  logic [7:0]       n_l;
  logic [MAX_LEN:0] max_full;
  logic             code_ovf;
  logic             idx_ovf;
  logic             last_len;
  logic             cnt_ok;

  // Count RAM addressing is length-1; the code-space limit for length L is 2^L.
  always_comb begin
    len_m1     = len - LEN_ONE;
    cnt_len_m1 = cnt_len - LEN_ONE;
    n_l        = counts[tbl][len_m1[CW-1:0]];
    max_full   = code + {{(MAX_LEN-7){1'b0}}, n_l} - CODE_ONE;
    code_ovf   = (code >> len) != '0;
    idx_ovf    = (idx == IDX_LIM);
    last_len   = (len == LEN_MAX);
    cnt_ok     = cnt_we && !busy && (cnt_len != '0) && (cnt_len <= LEN_MAX) &&
                 ({1'b0, cnt_tbl} < (TW+1)'(NUM_TABLES));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      tbl         <= '0;
      code        <= '0;
      idx         <= '0;
      len         <= '0;
      rem         <= '0;
      busy        <= 1'b0;
      code_we     <= 1'b0;
      code_tbl    <= '0;
      code_idx    <= '0;
      code_val    <= '0;
      code_len    <= '0;
      dec_we      <= 1'b0;
      dec_len     <= '0;
      dec_valid   <= 1'b0;
      dec_mincode <= '0;
      dec_maxcode <= '0;
      dec_valptr  <= '0;
      done        <= 1'b0;
      err_code    <= 1'b0;
      err_count   <= 1'b0;
      for (int t = 0; t < NUM_TABLES; t++)
        for (int l = 0; l < MAX_LEN; l++)
          counts[t][l] <= '0;
    end else begin
      code_we <= 1'b0;
      dec_we  <= 1'b0;
      done    <= 1'b0;
      if (cnt_ok)
        counts[cnt_tbl][cnt_len_m1[CW-1:0]] <= cnt_data;

      case (state)
        S_IDLE: begin
          if (start) begin
            tbl       <= start_tbl;
            code_tbl  <= start_tbl;
            err_code  <= 1'b0;
            err_count <= 1'b0;
            code      <= '0;
            idx       <= '0;
            len       <= LEN_ONE;
            busy      <= 1'b1;
            state     <= S_LEN;
          end
        end

        // Empty lengths fold the shift-and-advance step into this cycle.
        S_LEN: begin
          dec_we      <= 1'b1;
          dec_len     <= len;
          dec_valid   <= (n_l != '0);
          dec_mincode <= code[MAX_LEN-1:0];
          dec_maxcode <= (n_l != '0) ? max_full[MAX_LEN-1:0] : '0;
          dec_valptr  <= idx[IW-1:0];
          if (n_l != '0) begin
            rem   <= n_l;
            state <= S_EMIT;
          end else begin
            code  <= code << 1;
            len   <= len + LEN_ONE;
            state <= last_len ? S_FIN : S_LEN;
          end
        end

        S_EMIT: begin
          if (code_ovf || idx_ovf) begin
            err_code  <= code_ovf;
            err_count <= idx_ovf;
            state     <= S_FIN;
          end else begin
            code_we  <= 1'b1;
            code_val <= code[MAX_LEN-1:0];
            code_len <= len;
            code_idx <= idx[IW-1:0];
            idx      <= idx + IDX_ONE;
            rem      <= rem - 8'd1;
            if (rem == 8'd1) begin
              code  <= (code + CODE_ONE) << 1;
              len   <= len + LEN_ONE;
              state <= last_len ? S_FIN : S_LEN;
            end else begin
              code <= code + CODE_ONE;
            end
          end
        end

        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/jpeg_huffman_table_builder.md
# jpeg_huffman_table_builder

Sequential, parametrised canonical Huffman table builder for the JPEG entropy decoder. It holds the DHT length counts for up to `NUM_TABLES` tables, loaded through a write port. On command it walks one selected table and streams canonical code/length pairs one symbol per cycle. It also emits per-length decode entries (mincode/maxcode/valptr) and flags malformed DHT contents. The outputs feed the symbol-indexed code RAM and the Huffman decode-table registers.

## Interface
- `MAX_LEN`, 16: maximum code length; counts exist for lengths 1..`MAX_LEN`.
- `MAX_SYMS`, 256: maximum symbols per table.
- `NUM_TABLES`, 4: number of count sets held (e.g. DC0/DC1/AC0/AC1).
- `IW`, clog2(`MAX_SYMS`): symbol index width.
- `LW`, clog2(`MAX_LEN`+1): length field width.
- `TW`, clog2(`NUM_TABLES`), minimum 1: table select width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cnt_we`  in  1  count write strobe.
- `cnt_tbl`  in  `TW`  table for the count write.
- `cnt_len`  in  `LW`  length index 1..`MAX_LEN`; 0 or >`MAX_LEN` is ignored.
- `cnt_data`  in  8  number of codes of that length.
- `start`  in  1  build request, sampled in IDLE only.
- `start_tbl`  in  `TW`  table to build.
- `busy`  out  1  high from the cycle after start is accepted until done.
- `code_we`  out  1  one symbol emitted this cycle.
- `code_tbl`  out  `TW`  table being built.
- `code_idx`  out  `IW`  symbol index (HUFFVAL order).
- `code_val`  out  `MAX_LEN`  canonical code, right-aligned.
- `code_len`  out  `LW`  code length.
- `dec_we`  out  1  per-length decode entry valid this cycle.
- `dec_len`  out  `LW`  length of the entry.
- `dec_valid`  out  1  count for this length is nonzero.
- `dec_mincode`  out  `MAX_LEN`  first code of this length.
- `dec_maxcode`  out  `MAX_LEN`  last code of this length.
- `dec_valptr`  out  `IW`  symbol index of the first code of this length.
- `done`  out  1  one-cycle pulse at the end of a build (success or error).
- `err_code`  out  1  oversubscribed code space; sticky until the next accepted start.
- `err_count`  out  1  symbol total exceeds `MAX_SYMS`; sticky until the next accepted start.

## Operation
- Count storage: `NUM_TABLES`×`MAX_LEN`×8-bit registers. A write lands on the clock edge.
- `cnt_we` is ignored while `busy`.
- FSM states:
  - IDLE: accepted `start` latches `start_tbl`, clears `err_*`, zeroes the code accumulator (`MAX_LEN`+1 bits) and the index, sets L=1, then moves to LEN.
  - LEN: one cycle. Drives `dec_we`=1 with `dec_mincode`=code, `dec_maxcode`=code+N_L−1 (0 when N_L=0), `dec_valptr`=idx, `dec_valid`=(N_L≠0). Goes to EMIT if N_L>0, else to STEP.
  - EMIT: one symbol per cycle; `code_val`=code, `code_len`=L, `code_idx`=idx; then code+=1 and idx+=1. After N_L symbols, goes to STEP.
  - STEP: merged into the final EMIT cycle or the LEN cycle (no extra cycle). Does code<<=1 and L+=1. After L=`MAX_LEN`, goes to FIN.
  - FIN: `done`=1 for one cycle, then IDLE.
- Errors are checked before each emit:
  - code ≥ 2^L sets `err_code`.
  - idx = `MAX_SYMS` sets `err_count`.
  - On either error, no `code_we` that cycle, go straight to FIN.
- An `start` seen outside IDLE is ignored.

## Timing
- Reset values: all outputs 0, all counts 0, FSM in IDLE.
- Reset mid-build aborts immediately. No `done` pulse follows.
- Error-free build, with S = total symbols:
  - LEN cycles occupy `MAX_LEN` cycles; EMIT cycles occupy S cycles.
  - `done` asserts in cycle `MAX_LEN`+S+1 after the accepting edge.
  - `busy` falls together with `done`.
- `cnt_we` in the same cycle as an accepted `start` to the same table is written. The build uses the new value.
- `code_*` and `dec_*` are registered outputs. They are meaningful only while the matching `_we` is high.

## Test plan
- DC-luminance counts {0,1,5,1,1,1,1,1,1,0,…} on table 0 -> 12 emits:
  - idx0 code 00/len2; idx1..5 codes 2..6/len3; idx6 1110; … idx11 111111110/len9.
  - L3 decode entry: min 2, max 6, valptr 1.
  - `done` at cycle 29.
- All-zero table -> 16 `dec_we` with `dec_valid`=0, no `code_we`, `done` at cycle 17, no error.
- Count[1]=3 -> codes 0 and 1 emitted, then `err_code`=1, `done` the next cycle, `busy` low.
- Count[9]=255, count[10]=2 -> 256 emits, then `err_count`=1 and `done`. The 257th symbol is never written.
- Load different counts into tables 0 and 2, build table 2 -> `code_tbl`=2 and table 2 codes only. A rebuild of table 0 afterwards gives its original codes unchanged.
- Reset during EMIT -> outputs 0 and IDLE next cycle. A `start` during a build is ignored. A new `start` after reset works normally.
